// File: rtl/button_debouncer_mc.sv
// Multi-channel button debouncer: 2-FF sync, prescaled sampling, run-length filter,
// press/release pulses and a long-press hold flag per channel.

module button_debouncer_lane #(
    parameter int SAMPLES    = 8,
    parameter int ACTIVE_LOW = 1,
    parameter int HOLD_TICKS = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic noisy_i,
    output logic debounced_o,
    output logic pressed_o,
    output logic released_o,
    output logic held_o
);
    localparam int   CW   = $clog2(SAMPLES + 1);
    localparam int   HW   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic IDLE = (ACTIVE_LOW != 0);

    logic          sync1_q, sync2_q, x;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          deb_q, deb_d;
    logic          pr_q, pr_d, rl_q, rl_d;

    // Normalise so that 1 always means "pressed".
    assign x = sync2_q ^ IDLE;

    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        hold_d = hold_q;
        if (tick_i) begin
            if (x == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q + CW'(1) == CW'(SAMPLES)) begin
                deb_d = x;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (!deb_q) begin
            hold_d = '0;
        end else if (tick_i && hold_q != HW'(HOLD_TICKS)) begin
            hold_d = hold_q + HW'(1);
        end
        pr_d = deb_d & ~deb_q;
        rl_d = ~deb_d & deb_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            deb_q   <= 1'b0;
            pr_q    <= 1'b0;
            rl_q    <= 1'b0;
        end else begin
            sync1_q <= noisy_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            deb_q   <= deb_d;
            pr_q    <= pr_d;
            rl_q    <= rl_d;
        end
    end

    assign debounced_o = deb_q;
    assign pressed_o   = pr_q;
    assign released_o  = rl_q;
    // Gated by deb_q so held drops in the same cycle as the release.
    assign held_o      = (HOLD_TICKS != 0) && deb_q && (hold_q == HW'(HOLD_TICKS));
endmodule

module button_debouncer_mc #(
    parameter int CHANNELS   = 4,
    parameter int SAMPLES    = 8,
    parameter int DIV        = 1000,
    parameter int ACTIVE_LOW = 1,
    parameter int HOLD_TICKS = 500
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy_i,
    output logic [CHANNELS-1:0] debounced_o,
    output logic [CHANNELS-1:0] pressed_o,
    output logic [CHANNELS-1:0] released_o,
    output logic [CHANNELS-1:0] held_o
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick  = (pre_q == PW'(DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end

    button_debouncer_lane #(
        .SAMPLES    (SAMPLES),
        .ACTIVE_LOW (ACTIVE_LOW),
        .HOLD_TICKS (HOLD_TICKS)
    ) u_lane [CHANNELS-1:0] (
        .clock       (clock),
        .reset       (reset),
        .tick_i      (tick),
        .noisy_i     (noisy_i),
        .debounced_o (debounced_o),
        .pressed_o   (pressed_o),
        .released_o  (released_o),
        .held_o      (held_o)
    );
endmodule
